// File: rtl/muldiv_ctrl_if.sv
// EX-stage to HI/LO multiply/divide sequencer link: op issue and flush in,
// busy/done status and the HI/LO architectural registers out.
interface muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: MUL_LAT-cycle multiply, 32-cycle restoring divide, MTHI/MTLO next edge.
// busy holds off further issue (starts while busy are ignored); flush aborts with no HI/LO update.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'd31;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] opa_q;       // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0] opb_q;       // multiplier, or divisor magnitude
  logic [31:0] rem_q;
  logic        mul_signed_q;
  logic        sign_q_q;
  logic        sign_r_q;
  logic        div_zero_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic mul_go, div_go, mt_hi, mt_lo, finish;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mul_go  = 1'b0;
    div_go  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin mul_go = 1'b1; state_d = MUL; end
            OP_DIV,  OP_DIVU:  begin div_go = 1'b1; state_d = DIV; end
            OP_MTHI:           mt_hi = 1'b1;
            OP_MTLO:           mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        // flush on the last cycle suppresses the result write
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  logic        div_signed;
  logic [31:0] a_abs, b_abs;
  logic [63:0] mul_a_ext, mul_b_ext, product;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        q_bit;
  logic [31:0] quot_nxt, rem_nxt, q_res, r_res;

  always_comb begin
    div_signed = (bus.op == OP_DIV);
    a_abs = (div_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    b_abs = (div_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    mul_a_ext = mul_signed_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
    mul_b_ext = mul_signed_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
    product   = mul_a_ext * mul_b_ext;

    // one restoring step: bring in next dividend bit, try subtracting divisor
    shifted  = {rem_q, opa_q[31]};
    diff     = {1'b0, shifted} - {2'b00, opb_q};
    q_bit    = ~diff[33];
    rem_nxt  = q_bit ? diff[31:0] : shifted[31:0];
    quot_nxt = {opa_q[30:0], q_bit};

    // divide by zero leaves rem = |a|, which the sign_r fixup returns to a
    q_res = div_zero_q ? 32'hFFFF_FFFF : (sign_q_q ? (~quot_nxt + 32'd1) : quot_nxt);
    r_res = sign_r_q ? (~rem_nxt + 32'd1) : rem_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      mul_signed_q <= 1'b0;
      sign_q_q     <= 1'b0;
      sign_r_q     <= 1'b0;
      div_zero_q   <= 1'b0;
    end else if (mul_go) begin
      cnt_q        <= MUL_CNT;
      opa_q        <= bus.a;
      opb_q        <= bus.b;
      mul_signed_q <= (bus.op == OP_MULT);
    end else if (div_go) begin
      cnt_q      <= DIV_CNT;
      opa_q      <= a_abs;
      opb_q      <= b_abs;
      rem_q      <= '0;
      sign_q_q   <= div_signed & (bus.a[31] ^ bus.b[31]);
      sign_r_q   <= div_signed & bus.a[31];
      div_zero_q <= (bus.b == 32'd0);
    end else if (state_q != IDLE && !bus.flush && cnt_q != 6'd0) begin
      cnt_q <= cnt_q - 6'd1;
      if (state_q == DIV) begin
        opa_q <= quot_nxt;
        rem_q <= rem_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        if (state_q == MUL) begin
          hi_q <= product[63:32];
          lo_q <= product[31:0];
        end else begin
          hi_q <= r_res;
          lo_q <= q_res;
        end
      end
      if (mt_hi) hi_q <= bus.a;
      if (mt_lo) lo_q <= bus.a;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results, busy timing, flush, MTHI/MTLO, async reset.
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one start for a single cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges seen with busy=1; stops on the first negedge with busy=0.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int dn;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;

    // MULT -3 * 5 = -15
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    check("mult_cycles", 32'(n), 32'd3);
    check("mult_done", 32'(bus.done), 32'd1);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFF1);
    @(negedge clk);
    check("mult_done_pulse", 32'(bus.done), 32'd0);

    // MULTU (2^32-3) * 5 = 5*2^32 - 15
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    check("multu_cycles", 32'(n), 32'd3);
    check("multu_hi", bus.hi, 32'h0000_0004);
    check("multu_lo", bus.lo, 32'hFFFF_FFF1);

    // DIVU 100 / 7 = 14 r 2
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_cycles", 32'(n), 32'd32);
    check("divu_done", 32'(bus.done), 32'd1);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    @(negedge clk);
    check("divu_done_pulse", 32'(bus.done), 32'd0);

    // DIV -7 / 2 = -3 r -1 (truncating)
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    // DIV overflow
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);

    // DIVU by zero
    issue(3'd3, 32'd1234, 32'd0);
    wait_idle(n);
    check("divz_cycles", 32'(n), 32'd32);
    check("divz_lo", bus.lo, 32'hFFFF_FFFF);
    check("divz_hi", bus.hi, 32'd1234);

    // Preload HI/LO, then flush a DIV on busy cycle 10
    issue(3'd4, 32'h1111_1111, 32'd0);
    check("mthi_pre", bus.hi, 32'h1111_1111);
    issue(3'd5, 32'h1111_1111, 32'd0);
    check("mtlo_pre", bus.lo, 32'h1111_1111);
    issue(3'd2, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush10_busy", 32'(bus.busy), 32'd0);
    dn = 0;
    repeat (40) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    check("flush10_no_done", 32'(dn), 32'd0);
    check("flush10_hi", bus.hi, 32'h1111_1111);
    check("flush10_lo", bus.lo, 32'h1111_1111);

    // Flush on the final (32nd) busy cycle
    issue(3'd2, 32'd100, 32'd7);
    repeat (31) @(negedge clk);
    check("flush32_still_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush32_busy", 32'(bus.busy), 32'd0);
    check("flush32_done", 32'(bus.done), 32'd0);
    check("flush32_hi", bus.hi, 32'h1111_1111);
    check("flush32_lo", bus.lo, 32'h1111_1111);

    // MTHI updates hi next edge with no busy/done
    issue(3'd4, 32'hCAFE_0000, 32'd0);
    check("mthi_hi", bus.hi, 32'hCAFE_0000);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    check("mthi_done", 32'(bus.done), 32'd0);

    // MTLO with simultaneous flush is dropped
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'hDEAD_BEEF;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("mtlo_flush_lo", bus.lo, 32'h1111_1111);

    // MULT issued while DIVU busy is ignored; busy cycle 5 onward leaves 28
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n);
    check("ign_cycles", 32'(n), 32'd28);
    check("ign_lo", bus.lo, 32'd14);
    check("ign_hi", bus.hi, 32'd2);
    @(negedge clk);
    check("ign_no_extra_busy", 32'(bus.busy), 32'd0);

    // Async reset between edges mid-DIV
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    #1 rst = 1'b0;

    // DIVU 9 / 3 after reset
    issue(3'd3, 32'd9, 32'd3);
    wait_idle(n);
    check("post_rst_cycles", 32'(n), 32'd32);
    check("post_rst_lo", bus.lo, 32'd3);
    check("post_rst_hi", bus.hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
